// File: rtl/led_matrix_scanner_pkg.sv
// led_matrix_scanner_pkg: shared sizes, scanner states and row/frame types for the LED matrix path
package led_matrix_scanner_pkg;
    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;
    localparam int PWM_BITS    = 8;
    localparam int ROW_BITS    = $clog2(MATRIX_ROWS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } scan_state_e;

    typedef logic [MATRIX_COLS-1:0] row_word_t;
    typedef row_word_t [MATRIX_ROWS-1:0] frame_t;
endpackage

// File: rtl/led_matrix_scanner_frame_buffer.sv
// pattern_frame_buffer: staging/display double buffer with capture edge detect and tear-free swap
module pattern_frame_buffer
    import led_matrix_scanner_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  frame_t              frame_in,
    input  logic                pattern_valid,
    input  logic                swap_req,
    input  logic [ROW_BITS-1:0] row_idx,
    output logic                pending,
    output row_word_t           row_word,
    output logic                frame_dropped
);
    frame_t staging_q, staging_d, disp_q, disp_d;
    logic   valid_q, valid_d, pending_q, pending_d, dropped_q, dropped_d;
    logic   capture, swap;

    // A swap always takes the old staging words, so a capture on the swap edge survives as the next pending frame
    always_comb begin
        capture   = pattern_valid & ~valid_q;
        swap      = swap_req & pending_q;
        valid_d   = pattern_valid;
        staging_d = capture ? frame_in : staging_q;
        disp_d    = swap ? staging_q : disp_q;
        pending_d = capture | (pending_q & ~swap);
        dropped_d = capture & pending_q & ~swap;
    end

    // Buffer and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
            staging_q <= '0;
            disp_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
            staging_q <= staging_d;
            disp_q    <= disp_d;
        end
    end

    assign pending       = pending_q;
    assign row_word      = disp_q[row_idx];
    assign frame_dropped = dropped_q;
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-scanning 8x8 LED driver with blanking gaps, PWM dimming and frame-boundary swaps
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int DEAD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MATRIX_COLS-1:0] pattern_0,
    input  logic [MATRIX_COLS-1:0] pattern_1,
    input  logic [MATRIX_COLS-1:0] pattern_2,
    input  logic [MATRIX_COLS-1:0] pattern_3,
    input  logic [MATRIX_COLS-1:0] pattern_4,
    input  logic [MATRIX_COLS-1:0] pattern_5,
    input  logic [MATRIX_COLS-1:0] pattern_6,
    input  logic [MATRIX_COLS-1:0] pattern_7,
    input  logic                   pattern_valid,
    input  logic [PWM_BITS-1:0]    duty,
    output logic [MATRIX_ROWS-1:0] row_sel,
    output logic [MATRIX_COLS-1:0] col_data,
    output logic                   frame_done,
    output logic                   frame_dropped
);
    localparam logic [7:0]            LAST_BLANK = 8'(DEAD_CYCLES - 1);
    localparam logic [ROW_BITS-1:0]   LAST_ROW   = ROW_BITS'(MATRIX_ROWS - 1);
    localparam logic [PWM_BITS-1:0]   PWM_MAX    = '1;

    scan_state_e            state_q, state_d;
    logic [ROW_BITS-1:0]    row_q, row_d;
    logic [7:0]             blank_cnt_q, blank_cnt_d;
    logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d, duty_q, duty_d, pwm_nxt;
    logic [MATRIX_ROWS-1:0] row_sel_q, row_sel_d;
    logic [MATRIX_COLS-1:0] col_data_q, col_data_d;
    logic                   frame_done_q, frame_done_d;
    logic                   swap_req, pending;
    row_word_t              row_word;
    frame_t                 frame_in;

    assign frame_in = {pattern_7, pattern_6, pattern_5, pattern_4,
                       pattern_3, pattern_2, pattern_1, pattern_0};

    pattern_frame_buffer u_buf (
        .clk          (clk),
        .rst          (rst),
        .frame_in     (frame_in),
        .pattern_valid(pattern_valid),
        .swap_req     (swap_req),
        .row_idx      (row_q),
        .pending      (pending),
        .row_word     (row_word),
        .frame_dropped(frame_dropped)
    );

    // Scan sequencing; outputs are computed one cycle ahead so they land registered with their state
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        blank_cnt_d  = blank_cnt_q;
        pwm_cnt_d    = pwm_cnt_q;
        duty_d       = duty_q;
        row_sel_d    = '0;
        col_data_d   = '0;
        frame_done_d = 1'b0;
        swap_req     = 1'b0;
        pwm_nxt      = pwm_cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                swap_req = 1'b1;
                if (pending) begin
                    state_d     = ST_BLANK;
                    row_d       = '0;
                    blank_cnt_d = '0;
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == LAST_BLANK) begin
                    state_d    = ST_DRIVE;
                    pwm_cnt_d  = '0;
                    duty_d     = duty;
                    row_sel_d  = MATRIX_ROWS'(1) << row_q;
                    col_data_d = row_word & {MATRIX_COLS{duty != '0}};
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (pwm_cnt_q == PWM_MAX) begin
                    state_d      = ST_BLANK;
                    blank_cnt_d  = '0;
                    row_d        = row_q + 1'b1;
                    frame_done_d = row_q == LAST_ROW;
                    swap_req     = row_q == LAST_ROW;
                end else begin
                    pwm_cnt_d  = pwm_nxt;
                    row_sel_d  = row_sel_q;
                    col_data_d = row_word & {MATRIX_COLS{pwm_nxt < duty_q}};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            blank_cnt_q  <= '0;
            pwm_cnt_q    <= '0;
            duty_q       <= '0;
            row_sel_q    <= '0;
            col_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            blank_cnt_q  <= blank_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            duty_q       <= duty_d;
            row_sel_q    <= row_sel_d;
            col_data_q   <= col_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: randomized scoreboard bench against a timeline-based reference model
module tb_led_matrix_scanner;
    localparam int DEAD  = 2;
    localparam int ROWP  = DEAD + 256;
    localparam int FRAME = 8 * ROWP;

    typedef struct {
        int         cyc;
        logic [7:0] sel;
        logic [7:0] word;
        int         duty;
    } row_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pat [8];
    logic       pv = 1'b0;
    logic [7:0] duty = 8'd0;
    logic [7:0] row_sel, col_data;
    logic       frame_done, frame_dropped;

    int   total = 0, bad = 0;
    int   cyc = 0, to_err = 0, nrows = 0, ndrops = 0, m_ndrop = 0;
    bit   done = 0;

    row_t exp_rows [$];
    int   fd_q [$];
    int   drop_q [$];

    led_matrix_scanner #(.DEAD_CYCLES(DEAD)) dut (
        .clk          (clk),
        .rst          (rst),
        .pattern_0    (pat[0]),
        .pattern_1    (pat[1]),
        .pattern_2    (pat[2]),
        .pattern_3    (pat[3]),
        .pattern_4    (pat[4]),
        .pattern_5    (pat[5]),
        .pattern_6    (pat[6]),
        .pattern_7    (pat[7]),
        .pattern_valid(pv),
        .duty         (duty),
        .row_sel      (row_sel),
        .col_data     (col_data),
        .frame_done   (frame_done),
        .frame_dropped(frame_dropped)
    );

    always #5 clk = ~clk;

    // Reference model: frames as a timeline anchored at the scan start edge
    logic [7:0] m_stg [8];
    logic [7:0] m_disp [8];
    bit         m_running = 0, m_pend = 0, m_vprev = 0;
    int         m_start = 0;
    always @(posedge clk) begin
        int   ph, r;
        bit   cap, bnd, sw;
        row_t e;
        cyc++;
        if (rst) begin
            m_running = 0;
            m_pend    = 0;
            m_vprev   = 0;
            for (int i = 0; i < 8; i++) begin
                m_stg[i]  = 8'h00;
                m_disp[i] = 8'h00;
            end
            exp_rows.delete();
            fd_q.delete();
            drop_q.delete();
        end else begin
            cap     = pv && !m_vprev;
            m_vprev = pv;
            ph      = cyc - m_start;
            if (m_running && ph % ROWP == DEAD) begin
                r      = (ph / ROWP) % 8;
                e.cyc  = cyc;
                e.sel  = 8'(1 << r);
                e.word = m_disp[r];
                e.duty = int'(duty);
                exp_rows.push_back(e);
            end
            bnd = m_running && ph > 0 && ph % FRAME == 0;
            if (bnd) fd_q.push_back(cyc);
            sw = m_pend && (!m_running || bnd);
            if (sw) begin
                m_disp = m_stg;
                if (!m_running) begin
                    m_running = 1;
                    m_start   = cyc;
                end
            end
            if (cap) begin
                if (m_pend && !sw) begin
                    drop_q.push_back(cyc);
                    m_ndrop++;
                end
                m_stg = pat;
            end
            m_pend = cap || (m_pend && !sw);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a row, frame_done or frame_dropped
    bit   in_rec = 0, rst_seen = 0;
    int   idx = 0, errs = 0;
    row_t cur;
    always @(negedge clk) begin
        if (rst) begin
            in_rec   = 0;
            rst_seen = 1;
        end else begin
            if (rst_seen) begin
                chk("reset_row_sel", int'(row_sel), 0);
                chk("reset_col_data", int'(col_data), 0);
                rst_seen = 0;
            end
            if (row_sel == 8'h00 && col_data != 8'h00) chk("col_in_blank", int'(col_data), 0);
            if (frame_done) begin
                if (fd_q.size() == 0) chk("frame_done_spurious", cyc, -1);
                else chk("frame_done_cycle", cyc, fd_q.pop_front());
            end
            if (frame_dropped) begin
                ndrops++;
                if (drop_q.size() == 0) chk("frame_dropped_spurious", cyc, -1);
                else chk("frame_dropped_cycle", cyc, drop_q.pop_front());
            end
            if (row_sel != 8'h00) begin
                if (!in_rec) begin
                    in_rec = 1;
                    idx    = 0;
                    errs   = 0;
                    nrows++;
                    if (exp_rows.size() == 0) begin
                        chk("row_spurious", cyc, -1);
                        cur.cyc  = cyc;
                        cur.sel  = row_sel;
                        cur.word = 8'h00;
                        cur.duty = 0;
                    end else begin
                        cur = exp_rows.pop_front();
                    end
                    chk("row_start_cycle", cyc, cur.cyc);
                    chk("row_sel", int'(row_sel), int'(cur.sel));
                end
                if (row_sel != cur.sel) errs++;
                if (col_data != ((idx < cur.duty) ? cur.word : 8'h00)) errs++;
                idx++;
            end else if (in_rec) begin
                chk("row_len", idx, 256);
                chk("row_col_errors", errs, 0);
                in_rec = 0;
            end
            if (done) begin
                chk("phase_timeouts", to_err, 0);
                chk("rows_backlog_ok", int'(exp_rows.size() <= 1), 1);
                chk("frame_done_backlog", fd_q.size(), 0);
                chk("frame_dropped_backlog", drop_q.size(), 0);
                chk("frame_dropped_count", ndrops, m_ndrop);
                chk("rows_seen_enough", int'(nrows > 60), 1);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic capture();
        pv = 1'b1;
        tick(1);
        pv = 1'b0;
        tick(1);
    endtask

    task automatic wait_phase(input int period, input int off);
        for (int i = 0; i < FRAME + 10 && (cyc - m_start) % period != off; i++) tick(1);
        if ((cyc - m_start) % period != off) to_err++;
    endtask

    task automatic rand_pat();
        for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) pat[i] = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(3000);
        for (int i = 0; i < 8; i++) pat[i] = (i == 3 || i == 4) ? 8'hFF : 8'h18;
        duty = 8'd255;
        capture();
        tick(2 * FRAME + 200);
        duty = 8'd64;
        tick(FRAME);
        wait_phase(ROWP, 120);
        duty = 8'd0;
        tick(3 * ROWP);
        duty = 8'($urandom_range(1, 255));
        rand_pat();
        capture();
        wait_phase(FRAME, 2 * ROWP + 60);
        for (int i = 0; i < 8; i++) pat[i] = 8'hAA;
        capture();
        tick(2 * FRAME);
        wait_phase(FRAME, 100);
        rand_pat();
        capture();
        tick(300);
        rand_pat();
        capture();
        tick(2 * FRAME);
        wait_phase(FRAME, 500);
        rand_pat();
        capture();
        wait_phase(FRAME, FRAME - 1);
        rand_pat();
        capture();
        tick(2 * FRAME + 100);
        for (int k = 0; k < 6; k++) begin
            duty = 8'($urandom);
            rand_pat();
            capture();
            tick($urandom_range(200, 3000));
        end
        wait_phase(FRAME, 4 * ROWP + 100);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3000);
        duty = 8'($urandom_range(1, 255));
        rand_pat();
        pv = 1'b1;
        tick(500);
        pv = 1'b0;
        tick(FRAME + 300);
        done = 1;
        repeat (3) @(negedge clk);
        $display("FAIL end_not_reached: monitor did not finish");
        $fatal(1);
    end
endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Row-scanning driver for the 8×8 stimulus LED matrix; the consumer end of the pattern bus produced by the pattern generator. It captures the eight 8-bit row words on each new `pattern_valid` assertion into a staging buffer and swaps them into the display buffer only at frame boundaries, so no frame ever tears. It then drives the matrix one row at a time, with a blanking gap between rows and 8-bit PWM dimming. It sits between the pattern generator and the matrix row/column pins.

## Interface
- `DEAD_CYCLES`, default 2: blanking cycles before each row is driven; legal range 1..255.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous, active-high reset.
- `pattern_0` .. `pattern_7`  in  8 each: row words from the generator; bit i is column i.
- `pattern_valid  in  1`: level signal; a new frame is offered on its rising edge.
- `duty  in  8`: PWM on-time per row, in cycles out of 256.
- `row_sel  out  8`: one-hot active row; 0 during blanking and idle.
- `col_data  out  8`: column drive for the active row.
- `frame_done  out  1`: one-cycle pulse at the end of each displayed frame.
- `frame_dropped  out  1`: one-cycle pulse when a staged, not-yet-displayed frame is overwritten.

## Operation
- **Capture.** Register `valid_q <= pattern_valid`. A capture occurs on any edge where `pattern_valid & ~valid_q`.
  - On capture, all eight words load into staging and `pending <= 1`.
  - If `pending` was already 1 and no swap happens on the same edge, pulse `frame_dropped`. The newest words win.
- **Swap.** Display buffer `<=` staging and `pending <= 0`. This happens in exactly two places:
  - in IDLE when `pending` is 1;
  - at the last DRIVE cycle of row 7 when `pending` is 1.
- **Capture and swap on the same edge.** The swap takes the old staging contents. The new words enter staging and `pending` stays 1. `frame_dropped` is not pulsed.
- **State machine** (IDLE, BLANK, DRIVE):
  - IDLE: outputs 0. Go to BLANK with row 0 once `pending` is 1.
  - BLANK: outputs 0 for DEAD_CYCLES cycles, then go to DRIVE. On that transition, latch `duty` into `duty_q` and register `row_sel = 1 << row`.
  - DRIVE: 8-bit `pwm_cnt` runs 0..255. `col_data = disp[row] & {8{pwm_cnt < duty_q}}`. After `pwm_cnt == 255`:
    - `row` increments, wrapping 7→0;
    - state goes to BLANK;
    - if leaving row 7, pulse `frame_done`.
- **Duty.** Changes to `duty` take effect only at the next row start. `duty == 0` means fully dark; `duty == 255` means dark only in the `pwm_cnt == 255` cycle.
- **Holding a frame.** With no new capture, the display buffer is rescanned indefinitely.

## Timing
- **Reset values.** Registered outputs are all 0: `row_sel`, `col_data`, `frame_done`, `frame_dropped`. Internal state on reset:
  - state IDLE, row 0, both buffers 0;
  - `pending = 0`, `valid_q = 0`, all counters 0.
- **Reset mid-operation.** Outputs are 0 on the next cycle. Nothing is displayed until a new capture.
- **First light.** Take capture edge E0. Edge E1 performs the IDLE swap. `row_sel = 8'h01` is first visible after edge E(1+DEAD_CYCLES).
- **Periods.** One row period is DEAD_CYCLES+256 cycles; one frame is 8 row periods.
- **`frame_done`.** High during the first BLANK cycle of row 0 of the next frame.
- **Mutual exclusion.** `row_sel` and `col_data` are never nonzero in a BLANK cycle. `row_sel` never has more than one bit set.

## Structure
- **Shared package** holds:
  - `MATRIX_ROWS = 8`, `MATRIX_COLS = 8`, `PWM_BITS = 8`;
  - the scanner state enum (IDLE/BLANK/DRIVE);
  - the row-word type.
- **Sub-module `pattern_frame_buffer`** holds the staging and display arrays, the `pending` flag, edge detection, swap arbitration and `frame_dropped`. It exports the selected display row word.
- **Top module** holds the FSM, the row, blank and PWM counters, and the output registers.

## Test plan
All scenarios use DEAD_CYCLES=2.
1. **Idle after reset.** Reset, hold `pattern_valid=0` for 3000 cycles → `row_sel` and `col_data` stay 0, no pulses.
2. **Cross at full duty.** Capture a cross (rows 0-2 and 5-7 = 8'h18, rows 3-4 = 8'hFF) with `duty=255` →
   - `row_sel=8'h01` appears 3 edges after the capture edge;
   - row 3 shows `col_data=8'hFF` for 255 cycles, then 0;
   - `frame_done` pulses every 2064 cycles.
3. **PWM.** `duty=64` → exactly 64 nonzero `col_data` cycles per row. Change `duty` to 0 mid-row → the current row keeps 64 cycles and the next row is dark.
4. **Double buffering.** Capture pattern B (all 8'hAA) while row 2 of pattern A is shown → rows 2-7 still show A; B appears from row 0 right after `frame_done`.
5. **Dropped frame.** Two captures (B, then C) within one frame → one `frame_dropped` pulse; the next frame shows C. A capture landing on the swap edge → no drop, and the following frame shows the new words.
6. **Reset mid-DRIVE, held pattern.** Assert `rst` during row 4 → outputs are 0 next cycle and stay 0 until a new capture. Hold `pattern_valid` high for 500 cycles → only one capture occurs.
